// File: rtl/v_ctx_queue.sv
// Multi-context FIFO: CONTEXT_N queues of ENTRIES_N entries sharing one 1R1W SRAM, with per-context flush.
// Pop response registered (T+1); full contexts deassert push_rdy; responses have no backpressure.
module v_ctx_queue #(
    parameter int CONTEXT_N = 128,
    parameter int ENTRIES_N = 4,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [$clog2(CONTEXT_N)-1:0] push_ctx,
    input  logic [DATA_W-1:0]            push_data,
    output logic                         push_rdy,
    input  logic                         pop_vld,
    input  logic [$clog2(CONTEXT_N)-1:0] pop_ctx,
    input  logic                         flush_vld,
    input  logic [$clog2(CONTEXT_N)-1:0] flush_ctx,
    output logic                         rsp_vld,
    output logic [$clog2(CONTEXT_N)-1:0] rsp_ctx,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err
);
    localparam int CTX_W  = $clog2(CONTEXT_N);
    localparam int PTR_W  = $clog2(ENTRIES_N);
    localparam int CNT_W  = $clog2(ENTRIES_N + 1);
    localparam int ADDR_W = CTX_W + PTR_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRIES_N);

    logic [PTR_W-1:0]  head [CONTEXT_N];
    logic [PTR_W-1:0]  tail [CONTEXT_N];
    logic [CNT_W-1:0]  cnt  [CONTEXT_N];
    logic [DATA_W-1:0] mem  [CONTEXT_N*ENTRIES_N];

    logic              push_fire;
    logic              pop_ok;
    logic              same_ctx;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;

    logic              rsp_vld_q;
    logic              rsp_err_q;
    logic [CTX_W-1:0]  rsp_ctx_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Flush wins over push/pop to the same context; pop sees pre-push occupancy.
    assign push_rdy  = !rst && (cnt[push_ctx] != FULL) && !(flush_vld && (flush_ctx == push_ctx));
    assign push_fire = push_vld && push_rdy;
    assign pop_ok    = pop_vld && !rst && (cnt[pop_ctx] != '0) && !(flush_vld && (flush_ctx == pop_ctx));
    assign same_ctx  = (push_ctx == pop_ctx);
    assign waddr     = {push_ctx, tail[push_ctx]};
    assign raddr     = {pop_ctx, head[pop_ctx]};

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[waddr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CONTEXT_N; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_ctx_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            if (push_fire) begin
                tail[push_ctx] <= tail[push_ctx] + PTR_W'(1);
            end
            if (pop_ok) begin
                head[pop_ctx] <= head[pop_ctx] + PTR_W'(1);
            end
            if (push_fire && !(pop_ok && same_ctx)) begin
                cnt[push_ctx] <= cnt[push_ctx] + CNT_W'(1);
            end
            if (pop_ok && !(push_fire && same_ctx)) begin
                cnt[pop_ctx] <= cnt[pop_ctx] - CNT_W'(1);
            end
            if (flush_vld) begin
                head[flush_ctx] <= '0;
                tail[flush_ctx] <= '0;
                cnt[flush_ctx]  <= '0;
            end
            rsp_vld_q  <= pop_vld;
            rsp_err_q  <= pop_vld && !pop_ok;
            rsp_ctx_q  <= pop_vld ? pop_ctx : rsp_ctx_q;
            rsp_data_q <= pop_ok ? mem[raddr] : '0;
        end
    end

    // Gating by rst drops a response already in flight when reset arrives.
    assign rsp_vld  = rsp_vld_q && !rst;
    assign rsp_err  = rsp_err_q && !rst;
    assign rsp_ctx  = rst ? '0 : rsp_ctx_q;
    assign rsp_data = rst ? '0 : rsp_data_q;
endmodule

// File: tb/tb_v_ctx_queue.sv
// Bench for v_ctx_queue: directed scenarios then random traffic, checked against per-context queues.
module tb_v_ctx_queue;
    localparam int CN = 128;
    localparam int EN = 4;
    localparam int DW = 32;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_vld;
    logic [CW-1:0] push_ctx;
    logic [DW-1:0] push_data;
    logic          push_rdy;
    logic          pop_vld;
    logic [CW-1:0] pop_ctx;
    logic          flush_vld;
    logic [CW-1:0] flush_ctx;
    logic          rsp_vld;
    logic [CW-1:0] rsp_ctx;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    typedef logic [DW-1:0] q_t [$];
    q_t mq [CN];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    v_ctx_queue #(.CONTEXT_N(CN), .ENTRIES_N(EN), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_ctx  (push_ctx),
        .push_data (push_data),
        .push_rdy  (push_rdy),
        .pop_vld   (pop_vld),
        .pop_ctx   (pop_ctx),
        .flush_vld (flush_vld),
        .flush_ctx (flush_ctx),
        .rsp_vld   (rsp_vld),
        .rsp_ctx   (rsp_ctx),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive, check push_rdy, update the model, then check the response.
    task automatic cyc(input bit pv, input int pc, input logic [DW-1:0] pd,
                       input bit ov, input int oc, input bit fv, input int fc);
        bit            erdy;
        bit            eerr;
        logic [DW-1:0] ed;
        push_vld  = pv;
        push_ctx  = CW'(pc);
        push_data = pd;
        pop_vld   = ov;
        pop_ctx   = CW'(oc);
        flush_vld = fv;
        flush_ctx = CW'(fc);
        #1;
        erdy = (mq[pc].size() != EN) && !(fv && fc == pc);
        chk("push_rdy", {63'd0, push_rdy}, {63'd0, erdy});
        eerr = 1'b0;
        ed   = '0;
        if (ov) begin
            if (mq[oc].size() > 0 && !(fv && fc == oc)) ed = mq[oc].pop_front();
            else eerr = 1'b1;
        end
        if (pv && erdy) mq[pc].push_back(pd);
        if (fv) mq[fc].delete();
        @(posedge clk);
        #1;
        push_vld  = 1'b0;
        pop_vld   = 1'b0;
        flush_vld = 1'b0;
        chk("rsp_vld", {63'd0, rsp_vld}, {63'd0, ov});
        if (ov) begin
            chk("rsp_ctx", {57'd0, rsp_ctx}, 64'(oc));
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, eerr});
            chk("rsp_data", {32'd0, rsp_data}, {32'd0, ed});
        end
    endtask

    initial begin
        rst = 1'b1;
        push_vld = 1'b0; push_ctx = '0; push_data = '0;
        pop_vld = 1'b0;  pop_ctx = '0;
        flush_vld = 1'b0; flush_ctx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {63'd0, push_rdy}, 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_vld", {63'd0, rsp_vld}, 64'd0);
        chk("reset_err", {63'd0, rsp_err}, 64'd0);
        chk("reset_ctx", {57'd0, rsp_ctx}, 64'd0);
        chk("reset_data", {32'd0, rsp_data}, 64'd0);

        // Pop of an empty context
        cyc(0, 0, 0, 1, 5, 0, 0);

        // Fill ctx 3, observe full, drain in order, then underflow
        for (int i = 0; i < 4; i++) cyc(1, 3, 32'hA0 + i, 0, 0, 0, 0);
        cyc(1, 3, 32'hEE, 0, 0, 0, 0);
        cyc(0, 4, 0, 0, 0, 0, 0);
        cyc(1, 3, 32'hEF, 1, 3, 0, 0);
        cyc(1, 3, 32'hA4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 3, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0);

        // Pointer wrap on ctx 7
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) cyc(1, 7, 32'h10 + 3 * r + i, 0, 0, 0, 0);
            for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 7, 0, 0);
        end
        cyc(0, 0, 0, 1, 7, 0, 0);

        // Same-cycle push+pop: non-empty ctx 2 and empty ctx 9
        cyc(1, 2, 32'h55, 0, 0, 0, 0);
        cyc(1, 2, 32'h66, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(1, 9, 32'h99, 1, 9, 0, 0);
        cyc(0, 0, 0, 1, 9, 0, 0);

        // Flush ctx 1 while pushing it and popping ctx 0
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'hB0 + i, 0, 0, 0, 0);
        cyc(1, 0, 32'h77, 0, 0, 0, 0);
        cyc(1, 1, 32'hBB, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // Reset arriving right behind a valid pop
        cyc(1, 0, 32'h88, 0, 0, 0, 0);
        cyc(1, 6, 32'h61, 0, 0, 0, 0);
        pop_vld = 1'b1;
        pop_ctx = '0;
        @(posedge clk);
        #1;
        pop_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstwin_vld0", {63'd0, rsp_vld}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rstwin_vld", {63'd0, rsp_vld}, 64'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < CN; c++) mq[c].delete();
        #1;
        chk("postrst_vld", {63'd0, rsp_vld}, 64'd0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 6, 0, 1, 6, 0, 0);
        cyc(0, 3, 0, 0, 0, 0, 0);

        // Random traffic concentrated on a few contexts so full/empty/flush collide often
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 9) < 6, $urandom_range(0, 5), $urandom,
                $urandom_range(0, 9) < 5, $urandom_range(0, 5),
                $urandom_range(0, 19) == 0, $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
